// File: rtl/coproc_cmd_issuer.sv
// rtl/coproc_cmd_issuer.sv - host-side command issuer for the matrix coprocessor
// One command in flight: encode, strobe, wait for done or timeout, NOP gap, respond.
module coproc_cmd_issuer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_sel,
  input  logic [2:0]  cmd_row,
  input  logic [2:0]  cmd_col,
  input  logic [7:0]  cmd_data,
  output logic [17:0] instruction,
  output logic        wr,
  input  logic [7:0]  cp_data,
  input  logic        cp_done,
  input  logic        cp_addr_err,
  input  logic        cp_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [2:0]  rsp_flags
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_MULE  = 3'd5;

  localparam logic [7:0]  C_TIMEOUT = 8'(TIMEOUT_CYCLES);
  localparam logic [15:0] C_GAP     = 16'(GAP_CYCLES);

  logic [2:0]  r_state;
  logic [2:0]  r_op;
  logic [17:0] r_instruction;
  logic        r_wr;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_data;
  logic [2:0]  r_rsp_flags;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_gap_cnt;
  logic [17:0] w_enc;
  logic        w_accept;

  assign w_accept = cmd_valid && r_cmd_ready;

  always_comb begin
    w_enc = '0;
    case (cmd_op)
      OP_NOP:   w_enc = '0;
      OP_LOAD:  w_enc = {9'd0, cmd_col, cmd_row, 3'b001};
      OP_STORE: w_enc = {cmd_data, cmd_col, cmd_row, cmd_sel, 3'b010};
      OP_MULE:  w_enc = {7'd0, cmd_data, 3'b101};
      default:  w_enc = {15'd0, cmd_op};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= OP_NOP;
      r_instruction <= '0;
      r_wr          <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_flags   <= '0;
      r_wait_cnt    <= '0;
      r_gap_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_op        <= cmd_op;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            if (cmd_op == OP_NOP) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state       <= S_ISSUE;
              r_instruction <= w_enc;
              r_wr          <= (cmd_op == OP_STORE);
            end
          end
        end
        // A stale done from the previous command is ignored here.
        S_ISSUE: begin
          r_wr       <= 1'b0;
          r_wait_cnt <= 8'd1;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cp_done) begin
            r_rsp_data    <= (r_op == OP_LOAD) ? cp_data : 8'd0;
            r_rsp_flags   <= {1'b0, cp_ovf, cp_addr_err};
            r_instruction <= '0;
            r_gap_cnt     <= 16'd1;
            r_state       <= S_GAP;
          end else if (r_wait_cnt >= C_TIMEOUT) begin
            r_rsp_data    <= 8'd0;
            r_rsp_flags   <= {1'b1, cp_ovf, cp_addr_err};
            r_instruction <= '0;
            r_gap_cnt     <= 16'd1;
            r_state       <= S_GAP;
          end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt >= C_GAP) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_instruction <= '0;
          r_wr          <= 1'b0;
          r_cmd_ready   <= 1'b0;
          r_rsp_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign instruction = r_instruction;
  assign wr          = r_wr;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_flags   = r_rsp_flags;

endmodule
